// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg : shared FIFO constants and Gray/binary pointer helpers    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int PTR_MAX_WIDTH   = 32;

  function automatic logic [PTR_MAX_WIDTH-1:0] bin2gray(input logic [PTR_MAX_WIDTH-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Prefix-XOR by doubling shifts; upper zero bits leave narrow pointers intact.
  function automatic logic [PTR_MAX_WIDTH-1:0] gray2bin(input logic [PTR_MAX_WIDTH-1:0] gray);
    logic [PTR_MAX_WIDTH-1:0] bin;
    bin = gray;
    for (int s = 1; s < PTR_MAX_WIDTH; s = s * 2) begin
      bin = bin ^ (bin >> s);
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gray_to_bin : combinational Gray-to-binary converter               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of its own and all more-significant Gray bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule
`default_nettype wire

// File: rtl/rd_ptr_empty.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rd_ptr_empty : async-FIFO read pointer, read data, empty/level flags|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rd_ptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH          = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH          = FIFO_DATA_WIDTH,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray_sync,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AE_THRESH = ALMOST_EMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0]   r_ptr_bin_q, r_ptr_bin_d;
  logic [ADDR_WIDTH:0]   r_ptr_gray_q, r_ptr_gray_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  empty_q, empty_d;
  logic                  almost_empty_q, almost_empty_d;
  logic [ADDR_WIDTH:0]   rd_level_q, rd_level_d;
  logic                  underflow_q, underflow_d;

  logic [ADDR_WIDTH:0]    w_ptr_bin;
  logic [PTR_MAX_WIDTH-1:0] gray_wide;
  logic                   accept;

  gray_to_bin #(
    .WIDTH (PW)
  ) u_w_gray_to_bin (
    .gray (w_ptr_gray_sync),
    .bin  (w_ptr_bin)
  );

  // Flags and level are computed from the next pointer so they line up with it.
  always_comb begin
    accept         = rd_en & ~empty_q;
    r_ptr_bin_d    = accept ? r_ptr_bin_q + 1'b1 : r_ptr_bin_q;
    gray_wide      = bin2gray(PTR_MAX_WIDTH'(r_ptr_bin_d));
    r_ptr_gray_d   = gray_wide[ADDR_WIDTH:0];
    rd_data_d      = accept ? mem_rd_data : rd_data_q;
    rd_valid_d     = accept;
    underflow_d    = rd_en & empty_q;
    empty_d        = (r_ptr_gray_d == w_ptr_gray_sync);
    rd_level_d     = w_ptr_bin - r_ptr_bin_d;
    almost_empty_d = (rd_level_d <= AE_THRESH);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_ptr_bin_q    <= '0;
      r_ptr_gray_q   <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_level_q     <= '0;
      underflow_q    <= 1'b0;
    end else begin
      r_ptr_bin_q    <= r_ptr_bin_d;
      r_ptr_gray_q   <= r_ptr_gray_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_level_q     <= rd_level_d;
      underflow_q    <= underflow_d;
    end
  end

  assign mem_rd_addr  = r_ptr_bin_q[ADDR_WIDTH-1:0];
  assign r_ptr_gray   = r_ptr_gray_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_level     = rd_level_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_ptr_empty.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rd_ptr_empty : directed self-checking bench for rd_ptr_empty     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rd_ptr_empty;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       rd_en;
  logic [3:0] w_ptr_gray_sync;
  logic [7:0] mem_rd_data;
  logic [2:0] mem_rd_addr;
  logic [3:0] r_ptr_gray;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  rd_ptr_empty #(
    .ADDR_WIDTH          (3),
    .DATA_WIDTH          (8),
    .ALMOST_EMPTY_THRESH (1)
  ) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .rd_en           (rd_en),
    .w_ptr_gray_sync (w_ptr_gray_sync),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_addr     (mem_rd_addr),
    .r_ptr_gray      (r_ptr_gray),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .rd_level        (rd_level),
    .underflow       (underflow)
  );

  always #5 rd_clk = ~rd_clk;

  // Memory stand-in: word at address a is 0xA0 + a.
  assign mem_rd_data = 8'hA0 + {5'b0, mem_rd_addr};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    rd_rst = 1'b1;
    rd_en = 1'b0;
    w_ptr_gray_sync = 4'b0000;
    tick();
    tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_gray", 32'(r_ptr_gray), 32'h0);
    check("rst_level", 32'(rd_level), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);

    // Two words written
    rd_rst = 1'b0;
    w_ptr_gray_sync = 4'b0011;
    tick();
    check("fill_empty", 32'(empty), 32'd0);
    check("fill_level", 32'(rd_level), 32'd2);
    check("fill_aempty", 32'(almost_empty), 32'd0);

    rd_en = 1'b1;
    tick();
    check("drain0_valid", 32'(rd_valid), 32'd1);
    check("drain0_data", 32'(rd_data), 32'hA0);
    check("drain0_level", 32'(rd_level), 32'd1);
    check("drain0_aempty", 32'(almost_empty), 32'd1);
    check("drain0_gray", 32'(r_ptr_gray), 32'b0001);
    check("drain0_addr", 32'(mem_rd_addr), 32'd1);
    tick();
    check("drain1_valid", 32'(rd_valid), 32'd1);
    check("drain1_data", 32'(rd_data), 32'hA1);
    check("drain1_empty", 32'(empty), 32'd1);
    check("drain1_gray", 32'(r_ptr_gray), 32'b0011);
    check("drain1_level", 32'(rd_level), 32'd0);

    // Read while empty
    tick();
    check("uflow_pulse", 32'(underflow), 32'd1);
    check("uflow_valid", 32'(rd_valid), 32'd0);
    check("uflow_gray", 32'(r_ptr_gray), 32'b0011);
    check("uflow_addr", 32'(mem_rd_addr), 32'd2);
    check("uflow_data_hold", 32'(rd_data), 32'hA1);
    rd_en = 1'b0;
    tick();
    check("uflow_one_cycle", 32'(underflow), 32'd0);

    // Full level from pointer 0
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    w_ptr_gray_sync = 4'b1100;
    tick();
    check("full_level", 32'(rd_level), 32'd8);
    check("full_aempty", 32'(almost_empty), 32'd0);
    check("full_empty", 32'(empty), 32'd0);

    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("full_rd_valid", 32'(rd_valid), 32'd1);
      check("full_rd_data", 32'(rd_data), 32'hA0 + 32'(i));
      check("full_rd_level", 32'(rd_level), 32'(7 - i));
    end
    check("full_done_gray", 32'(r_ptr_gray), 32'b1100);
    check("full_done_empty", 32'(empty), 32'd1);

    // Writer wraps to 0 (binary 16 mod 16); drain across the pointer wrap
    rd_en = 1'b0;
    w_ptr_gray_sync = 4'b0000;
    tick();
    check("wrap_level", 32'(rd_level), 32'd8);
    check("wrap_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("wrap_gray_15", 32'(r_ptr_gray), 32'b1000);
    check("wrap_addr_15", 32'(mem_rd_addr), 32'd7);
    tick();
    check("wrap_gray_0", 32'(r_ptr_gray), 32'b0000);
    check("wrap_addr_0", 32'(mem_rd_addr), 32'd0);
    check("wrap_empty_end", 32'(empty), 32'd1);
    check("wrap_last_data", 32'(rd_data), 32'hA7);

    // Simultaneous read and write at level 1
    rd_en = 1'b0;
    w_ptr_gray_sync = 4'b0001;
    tick();
    check("sim_pre_level", 32'(rd_level), 32'd1);
    rd_en = 1'b1;
    w_ptr_gray_sync = 4'b0011;
    tick();
    check("sim_empty", 32'(empty), 32'd0);
    check("sim_level", 32'(rd_level), 32'd1);
    check("sim_valid", 32'(rd_valid), 32'd1);
    check("sim_data", 32'(rd_data), 32'hA0);
    check("sim_gray", 32'(r_ptr_gray), 32'b0001);

    // Reset dominates a pending read
    rd_rst = 1'b1;
    tick();
    check("midrst_gray", 32'(r_ptr_gray), 32'h0);
    check("midrst_addr", 32'(mem_rd_addr), 32'd0);
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_level", 32'(rd_level), 32'd0);
    rd_rst = 1'b0;
    rd_en = 1'b0;
    tick();
    check("postrst_empty", 32'(empty), 32'd0);
    check("postrst_level", 32'(rd_level), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
